counter_load_seq: RTL and testbench
===================================

// Module: counter_load_seq
// PURPOSE
//  Upstream feeder for the loadable 8-bit counter. Buffers load values from a
//  valid/ready producer in a small FIFO and replays them to the counter's
//  wdata/wr port as single-cycle wr strobes, spaced by a programmable hold-off.
//  Keeps a wrapping count of issued loads for debug and visibility.
// PARAMETERS
//  WIDTH    8  width of load value, wdata and in_data
//  DEPTH    4  FIFO entries; power of two, >=2
//  HOLDOFF  2  extra idle cycles after each wr pulse (0..15)
// PORTS
//  clk       in   1        clock; all state updates on posedge
//  reset     in   1        asynchronous, active-low reset (0 = reset)
//  flush     in   1        synchronous clear of FIFO and sequencer
//  in_valid  in   1        producer has a load value
//  in_data   in   WIDTH    load value
//  in_ready  out  1        FIFO can accept; = (level != DEPTH) && !flush
//  wdata     out  WIDTH    value to counter; registered; held between pulses
//  wr        out  1        one-cycle load strobe to counter; registered
//  level     out  log2(DEPTH)+1  entries currently buffered
//  busy      out  1        state != IDLE || level != 0
//  load_cnt  out  8        number of wr pulses issued, mod 256
// BEHAVIOUR
//  - Reset (reset=0, async): wdata=0, wr=0, level=0, load_cnt=0, state=IDLE,
//    FIFO pointers=0. in_ready=1 and busy=0 while reset is held and after release.
//  - Push: an entry is written on a posedge with in_valid && in_ready. in_ready
//    is combinational and ignores a same-cycle pop, so a full FIFO never accepts.
//  - FSM states: IDLE, HOLD.
//    IDLE: if level!=0 at the posedge, pop head: wdata<=head, wr<=1,
//      load_cnt<=load_cnt+1, cnt<=HOLDOFF, go to HOLD. Otherwise wr<=0.
//    HOLD: wr<=0. If cnt==0, go to IDLE; else cnt<=cnt-1.
//  - Timing: wr is high for exactly 1 cycle. Consecutive wr rising edges are
//    HOLDOFF+2 cycles apart when data is available. Latency from an accepted
//    push into an empty idle block to wr=1 is 1 clock (wr is high after the
//    next posedge).
//  - Simultaneous push and pop in one cycle: both happen and level is unchanged.
//    Pop sees the old head only, so there is no bypass of the pushed entry.
//  - Ordering: strict FIFO. Pointers wrap modulo DEPTH. Values are never
//    dropped or duplicated.
//  - flush=1 at a posedge: FIFO emptied (level=0), state=IDLE, wr<=0, cnt=0.
//    A same-cycle push is dropped (in_ready=0). wdata and load_cnt are
//    retained. Flush during a wr-high cycle leaves that pulse 1 cycle long.
//  - load_cnt wraps 8'hFF -> 8'h00 with no flag.
//  - Reset asserted mid-burst: all state is cleared immediately. No further wr
//    pulses until new pushes arrive after release.
// TESTING
//  1 Reset: hold reset=0 for 50 time units with random inputs -> wr=0, wdata=0,
//    level=0, in_ready=1, busy=0, load_cnt=0.
//  2 Single load: push 8'h55 at cycle n -> wr=1 with wdata=8'h55 in cycle n+1
//    only; load_cnt=1; wdata stays 8'h55 afterwards; busy drops after HOLD.
//  3 Fill/stall: push 8'h01..8'h05 back-to-back with wr draining -> in_ready=0
//    when level=4; in the order issued, wr pulses carry 01,02,03,04,05;
//    pulses 4 cycles apart (HOLDOFF=2); no data loss.
//  4 Full + pop race: with level=4 and in_valid=1 during a pop cycle -> push is
//    not accepted that cycle, level=3 next cycle, and the entry is accepted on
//    the following cycle.
//  5 Flush: flush after 2 of 4 pushes have issued -> no further wr, level=0,
//    wdata holds the last issued value, and load_cnt=2.
//  6 Reset mid-burst / wrap: pull reset low between pulses -> outputs cleared
//    asynchronously. Separately, issue 256 loads -> load_cnt returns to 8'h00.

Source files
------------

// File: rtl/counter_load_seq_if.sv
// Producer-side valid/ready handshake carrying load values into counter_load_seq.
interface counter_load_seq_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/counter_load_seq.sv
// Buffers producer load values in a small FIFO and replays them to the counter
// as single-cycle wr strobes separated by a programmable hold-off.
module counter_load_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  counter_load_seq_if.slave        in_if,
  output logic [WIDTH-1:0]         wdata,
  output logic                     wr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic [7:0]               load_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 4;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic [7:0]       load_cnt_q, load_cnt_d;
  logic             push, pop;

  // in_ready deliberately ignores a same-cycle pop so a full FIFO never accepts.
  assign in_if.in_ready = (level_q != LW'(DEPTH)) && !flush;
  assign push           = in_if.in_valid && in_if.in_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_if.in_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    load_cnt_d = load_cnt_q;
    pop        = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (level_q != '0) begin
            pop        = 1'b1;
            wdata_d    = mem_q[rd_ptr_q];
            wr_d       = 1'b1;
            load_cnt_d = load_cnt_q + 8'd1;
            cnt_d      = CW'(HOLDOFF);
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Pointer/level bookkeeping; flush empties the FIFO and drops any push.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      load_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      load_cnt_q <= load_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
    end
  end

  assign wdata    = wdata_q;
  assign wr       = wr_q;
  assign level    = level_q;
  assign load_cnt = load_cnt_q;
  assign busy     = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_counter_load_seq.sv
// Directed self-checking bench for counter_load_seq with hand-computed expectations.
module tb_counter_load_seq;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned HOLDOFF = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [WIDTH-1:0] wdata;
  logic             wr;
  logic [2:0]       level;
  logic             busy;
  logic [7:0]       load_cnt;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_lc;

  counter_load_seq_if #(.WIDTH(WIDTH)) bus ();

  counter_load_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_if    (bus),
    .wdata    (wdata),
    .wr       (wr),
    .level    (level),
    .busy     (busy),
    .load_cnt (load_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20 && busy; c++) step();
    check("idle", 32'(busy), 32'd0);
  endtask

  // Offers n consecutive values and checks order, spacing and load count of each pulse.
  task automatic run_stream(input int n, input logic [7:0] base, output int maxlvl);
    int   sent = 0;
    int   got  = 0;
    int   cyc  = 0;
    int   last = 0;
    logic acc;
    maxlvl = 0;
    while (got < n && cyc < n * 6 + 20) begin
      bus.in_valid = (sent < n);
      bus.in_data  = 8'(base + 8'(sent));
      @(negedge clk);
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (level == 3'd4) check("full_rdy", 32'(bus.in_ready), 32'd0);
      acc = bus.in_valid && bus.in_ready;
      step();
      cyc++;
      if (acc) sent++;
      if (wr) begin
        exp_lc = exp_lc + 8'd1;
        check("ord", 32'(wdata), 32'(8'(base + 8'(got))));
        check("lcnt", 32'(load_cnt), 32'(exp_lc));
        if (got > 0) check("gap", 32'(cyc - last), 32'(HOLDOFF + 2));
        last = cyc;
        got++;
      end
    end
    bus.in_valid = 1'b0;
    check("npulse", 32'(got), 32'(n));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_wr"},    32'(wr),           32'd0);
    check({tag, "_wdata"}, 32'(wdata),        32'd0);
    check({tag, "_level"}, 32'(level),        32'd0);
    check({tag, "_rdy"},   32'(bus.in_ready), 32'd1);
    check({tag, "_busy"},  32'(busy),         32'd0);
    check({tag, "_lcnt"},  32'(load_cnt),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int mx;
    int k;
    int pulses;

    // Reset held with random producer activity
    reset        = 1'b0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (5) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom);
    end
    #1;
    check_cleared("rst_hold");
    bus.in_valid = 1'b0;
    step();
    reset  = 1'b1;
    exp_lc = 8'd0;
    step();
    check_cleared("rst_rel");

    // Single load
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    step();
    bus.in_valid = 1'b0;
    check("s_lvl1", 32'(level), 32'd1);
    check("s_wr0",  32'(wr),    32'd0);
    check("s_busy", 32'(busy),  32'd1);
    step();
    check("s_wr1",   32'(wr),       32'd1);
    check("s_wdata", 32'(wdata),    32'h55);
    check("s_lcnt",  32'(load_cnt), 32'd1);
    check("s_lvl0",  32'(level),    32'd0);
    exp_lc = 8'd1;
    step();
    check("s_wr_off", 32'(wr),    32'd0);
    check("s_hold",   32'(wdata), 32'h55);
    step();
    check("s_busy_hold", 32'(busy), 32'd1);
    step();
    check("s_busy_done", 32'(busy),  32'd0);
    check("s_wdata_ret", 32'(wdata), 32'h55);

    // Fill/stall with 01..05
    run_stream(5, 8'h01, mx);
    check("fill_max", 32'(mx), 32'd4);
    wait_idle();

    // Full FIFO racing a pop
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'hA0 + 8'(i));
      step();
      if (i == 1) begin
        check("r_wr_a0", 32'(wr),    32'd1);
        check("r_wd_a0", 32'(wdata), 32'hA0);
        exp_lc = exp_lc + 8'd1;
      end
    end
    bus.in_data = 8'hA5;
    @(negedge clk);
    check("r_full_lvl", 32'(level),        32'd4);
    check("r_full_rdy", 32'(bus.in_ready), 32'd0);
    step();
    exp_lc = exp_lc + 8'd1;
    check("r_pop_lvl",  32'(level),        32'd3);
    check("r_pop_wr",   32'(wr),           32'd1);
    check("r_pop_wd",   32'(wdata),        32'hA1);
    check("r_pop_lcnt", 32'(load_cnt),     32'(exp_lc));
    check("r_pop_rdy",  32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("r_acc_lvl", 32'(level), 32'd4);
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      step();
      if (wr) begin
        check("r_ord", 32'(wdata), 32'(8'(8'hA2 + 8'(k))));
        k++;
        exp_lc = exp_lc + 8'd1;
      end
    end
    check("r_n", 32'(k), 32'd4);
    check("r_lcnt", 32'(load_cnt), 32'(exp_lc));
    wait_idle();

    // Reset asserted mid-burst, between pulses
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'hC0 + 8'(i));
      step();
    end
    bus.in_valid = 1'b0;
    check("m_pre_lvl", 32'(level), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check_cleared("m_async");
    step();
    check_cleared("m_held");
    reset  = 1'b1;
    exp_lc = 8'd0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (wr) pulses++;
    end
    check("m_no_wr", 32'(pulses), 32'd0);

    // Flush after two of four loads have issued
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'hB0 + 8'(i));
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    check("f_wr",   32'(wr),       32'd1);
    check("f_wd",   32'(wdata),    32'hB1);
    check("f_lvl",  32'(level),    32'd2);
    check("f_lcnt", 32'(load_cnt), 32'd2);
    flush = 1'b1;
    @(negedge clk);
    check("f_rdy", 32'(bus.in_ready), 32'd0);
    step();
    flush = 1'b0;
    check("f_wr_off", 32'(wr),       32'd0);
    check("f_lvl0",   32'(level),    32'd0);
    check("f_busy",   32'(busy),     32'd0);
    check("f_wd_ret", 32'(wdata),    32'hB1);
    check("f_lc_ret", 32'(load_cnt), 32'd2);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (wr) pulses++;
    end
    check("f_no_wr", 32'(pulses), 32'd0);

    // 256 loads wrap load_cnt back to zero
    reset = 1'b0;
    step();
    reset  = 1'b1;
    exp_lc = 8'd0;
    run_stream(256, 8'h00, mx);
    check("w_lcnt", 32'(load_cnt), 32'd0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
